// File: rtl/dc_wr_fifo_pkg.sv
// dc_wr_fifo_pkg: shared size encodings, store entry type and cache-line helpers for the store write buffer.
package dc_wr_fifo_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int LINE_OFS_W = 4;
  localparam int LINE_W = 32 - LINE_OFS_W;
  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;
  localparam logic [1:0] SZ_8B = 2'd3;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } entry_t;
  function automatic logic [LINE_W-1:0] start_line(input logic [31:0] a);
    return LINE_W'(a >> LINE_OFS_W);
  endfunction
  // End address wraps at 32 bits; the carry is intentionally dropped.
  function automatic logic [LINE_W-1:0] end_line(input logic [31:0] a, input logic [1:0] s);
    return LINE_W'((a + ((32'd1 << s) - 32'd1)) >> LINE_OFS_W);
  endfunction
endpackage

// File: rtl/dc_wr_fifo_if.sv
// dc_wr_fifo_if: writeback push, cache write port, load probe and status flags of the store write buffer.
interface dc_wr_fifo_if;
  logic        wb_push;
  logic [31:0] wb_addr;
  logic [1:0]  wb_size;
  logic [63:0] wb_data;
  logic        mem_wr_done;
  logic        v_mem_read;
  logic [31:0] mem_rd_addr;
  logic [1:0]  mem_rd_size;
  logic [31:0] mem_wr_addr;
  logic [1:0]  mem_wr_size;
  logic [63:0] mem_wr_data;
  logic        wr_fifo_empty;
  logic        wr_fifo_to_be_full;
  logic        wr_fifo_full;
  logic        mem_conflict;
  logic        wr_fifo_ovf;
  modport master (
    output wb_push, wb_addr, wb_size, wb_data, mem_wr_done, v_mem_read, mem_rd_addr, mem_rd_size,
    input  mem_wr_addr, mem_wr_size, mem_wr_data, wr_fifo_empty, wr_fifo_to_be_full, wr_fifo_full,
           mem_conflict, wr_fifo_ovf
  );
  modport slave (
    input  wb_push, wb_addr, wb_size, wb_data, mem_wr_done, v_mem_read, mem_rd_addr, mem_rd_size,
    output mem_wr_addr, mem_wr_size, mem_wr_data, wr_fifo_empty, wr_fifo_to_be_full, wr_fifo_full,
           mem_conflict, wr_fifo_ovf
  );
endinterface

// File: rtl/dc_wr_fifo_line_cmp.sv
// wr_fifo_line_cmp: flags a store whose start or end cache line matches the load's start or end line.
module wr_fifo_line_cmp
  import dc_wr_fifo_pkg::*;
(
  input  logic        vld,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        hit
);
  logic [LINE_W-1:0] ss, se, ls, le;
  assign ss = start_line(st_addr);
  assign se = end_line(st_addr, st_size);
  assign ls = start_line(ld_addr);
  assign le = end_line(ld_addr, ld_size);
  assign hit = vld & (ss == ls | ss == le | se == ls | se == le);
endmodule

// File: rtl/dc_wr_fifo.sv
// dc_wr_fifo: in-order store write buffer feeding the data cache, with a line-granular load hazard check.
module dc_wr_fifo
  import dc_wr_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst_n,
  dc_wr_fifo_if.slave bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  entry_t            ram [DEPTH];
  logic [PTR_W-1:0]  rptr, wptr;
  logic [PTR_W:0]    cnt;
  logic              empty, full, push, pop, ovf;
  logic [DEPTH:0]    hit;
  assign empty = cnt == '0;
  assign full  = cnt == FULL_CNT;
  assign pop   = bus.mem_wr_done & ~empty;
  // A pop in the same cycle frees the slot, so a push to a full buffer still lands.
  assign push  = bus.wb_push & (~full | pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      rptr <= pop ? rptr + 1'b1 : rptr;
      wptr <= push ? wptr + 1'b1 : wptr;
      cnt  <= (push & ~pop) ? cnt + 1'b1 : (pop & ~push) ? cnt - 1'b1 : cnt;
      ovf  <= ovf | (bus.wb_push & ~push);
    end
  always_ff @(posedge clk)
    if (push) ram[wptr] <= '{addr: bus.wb_addr, size: bus.wb_size, data: bus.wb_data};
  assign bus.mem_wr_addr        = ram[rptr].addr;
  assign bus.mem_wr_size        = ram[rptr].size;
  assign bus.mem_wr_data        = ram[rptr].data;
  assign bus.wr_fifo_empty      = empty;
  assign bus.wr_fifo_full       = full;
  assign bus.wr_fifo_to_be_full = cnt >= FULL_CNT - 1'b1;
  assign bus.wr_fifo_ovf        = ovf;
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off = PTR_W'(g) - rptr;
    wr_fifo_line_cmp u_cmp (
      .vld     ({1'b0, off} < cnt),
      .st_addr (ram[g].addr),
      .st_size (ram[g].size),
      .ld_addr (bus.mem_rd_addr),
      .ld_size (bus.mem_rd_size),
      .hit     (hit[g])
    );
  end
  wr_fifo_line_cmp u_cmp_in (
    .vld     (bus.wb_push),
    .st_addr (bus.wb_addr),
    .st_size (bus.wb_size),
    .ld_addr (bus.mem_rd_addr),
    .ld_size (bus.mem_rd_size),
    .hit     (hit[DEPTH])
  );
  assign bus.mem_conflict = bus.v_mem_read & |hit;
endmodule

// File: tb/tb_dc_wr_fifo.sv
// tb_dc_wr_fifo: directed checks of ordering, flags, overflow, wrap, reset and load hazard detection.
module tb_dc_wr_fifo;
  import dc_wr_fifo_pkg::*;
  logic clk, rst_n;
  int   n_chk, n_fail;
  dc_wr_fifo_if bus();
  dc_wr_fifo u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.wb_push = 0; bus.wb_addr = 0; bus.wb_size = 0; bus.wb_data = 0;
    bus.mem_wr_done = 0; bus.v_mem_read = 0; bus.mem_rd_addr = 0; bus.mem_rd_size = 0;
  endtask
  task automatic set_push(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    bus.wb_push = 1; bus.wb_addr = a; bus.wb_size = s; bus.wb_data = d;
  endtask
  task automatic check_flags(input string tag, input logic e, input logic tbf, input logic f, input logic o);
    check({tag, "_empty"}, 64'(bus.wr_fifo_empty), 64'(e));
    check({tag, "_tbf"}, 64'(bus.wr_fifo_to_be_full), 64'(tbf));
    check({tag, "_full"}, 64'(bus.wr_fifo_full), 64'(f));
    check({tag, "_ovf"}, 64'(bus.wr_fifo_ovf), 64'(o));
  endtask
  task automatic do_reset;
    idle();
    rst_n = 0;
    #1;
    check_flags("rst", 1, 0, 0, 0);
    check("rst_conflict", 64'(bus.mem_conflict), 64'd0);
    tick();
    rst_n = 1;
  endtask
  task automatic check_head(input string tag, input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    check({tag, "_addr"}, 64'(bus.mem_wr_addr), 64'(a));
    check({tag, "_size"}, 64'(bus.mem_wr_size), 64'(s));
    check({tag, "_data"}, bus.mem_wr_data, d);
  endtask
  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1;
    #2;
    do_reset();
    // In-order push and retire of three stores
    set_push(32'h1000, SZ_4B, 64'hA1); tick();
    check("p1_empty", 64'(bus.wr_fifo_empty), 64'd0);
    check_head("p1_head", 32'h1000, SZ_4B, 64'hA1);
    set_push(32'h1010, SZ_8B, 64'hB2); tick();
    set_push(32'h2000, SZ_1B, 64'hC3); tick();
    idle();
    bus.mem_wr_done = 1;
    check_head("pop1", 32'h1000, SZ_4B, 64'hA1); tick();
    check_head("pop2", 32'h1010, SZ_8B, 64'hB2); tick();
    check_head("pop3", 32'h2000, SZ_1B, 64'hC3);
    check("pop3_empty", 64'(bus.wr_fifo_empty), 64'd0);
    tick();
    check("pop_done_empty", 64'(bus.wr_fifo_empty), 64'd1);
    tick();
    check("done_when_empty", 64'(bus.wr_fifo_empty), 64'd1);
    idle();
    // Fill, overflow, push+pop while full
    for (int i = 0; i < 8; i++) begin
      set_push(32'h5000 + 32'(i * 16), SZ_4B, 64'(100 + i)); tick();
      if (i == 6) check_flags("cnt7", 0, 1, 0, 0);
    end
    check_flags("cnt8", 0, 1, 1, 0);
    set_push(32'hDEAD0000, SZ_8B, 64'hDEAD); tick();
    check_flags("ovf", 0, 1, 1, 1);
    check_head("ovf_head", 32'h5000, SZ_4B, 64'd100);
    set_push(32'h6000, SZ_2B, 64'h6666); bus.mem_wr_done = 1; tick();
    check_flags("full_pp", 0, 1, 1, 1);
    bus.wb_push = 0;
    for (int i = 1; i < 8; i++) begin
      check_head("drain", 32'h5000 + 32'(i * 16), SZ_4B, 64'(100 + i)); tick();
    end
    check_head("drain_tail", 32'h6000, SZ_2B, 64'h6666); tick();
    check_flags("drained", 1, 0, 0, 1);
    do_reset();
    // Pending store spanning two lines
    set_push(32'h100C, SZ_8B, 64'h11); tick();
    idle();
    bus.v_mem_read = 1; bus.mem_rd_addr = 32'h1010; bus.mem_rd_size = SZ_1B; #1;
    check("span_hit", 64'(bus.mem_conflict), 64'd1);
    bus.mem_rd_addr = 32'h1020; bus.mem_rd_size = SZ_4B; #1;
    check("span_miss", 64'(bus.mem_conflict), 64'd0);
    bus.mem_rd_addr = 32'h1008; bus.v_mem_read = 0; #1;
    check("no_read", 64'(bus.mem_conflict), 64'd0);
    bus.mem_wr_done = 1; tick();
    idle();
    // Incoming push checked in its own cycle
    check("pre_in_empty", 64'(bus.wr_fifo_empty), 64'd1);
    set_push(32'h3000, SZ_4B, 64'h33);
    bus.v_mem_read = 1; bus.mem_rd_addr = 32'h3004; bus.mem_rd_size = SZ_2B; #1;
    check("in_hit", 64'(bus.mem_conflict), 64'd1);
    check("in_no_bypass", 64'(bus.wr_fifo_empty), 64'd1);
    tick();
    idle();
    bus.mem_wr_done = 1; tick();
    idle();
    // Head still counts while it pops
    set_push(32'h4000, SZ_4B, 64'h44); tick();
    idle();
    bus.mem_wr_done = 1; bus.v_mem_read = 1; bus.mem_rd_addr = 32'h4008; bus.mem_rd_size = SZ_4B; #1;
    check("pop_hit", 64'(bus.mem_conflict), 64'd1);
    tick();
    bus.mem_wr_done = 0; #1;
    check("after_pop", 64'(bus.mem_conflict), 64'd0);
    check("after_pop_empty", 64'(bus.wr_fifo_empty), 64'd1);
    idle();
    // Continuous stream across the pointer wrap, then asynchronous reset
    set_push(32'h7000, SZ_8B, 64'h700); tick();
    for (int k = 1; k <= 20; k++) begin
      set_push(32'h7000 + 32'(k * 16), SZ_8B, 64'(32'h700 + k));
      bus.mem_wr_done = 1;
      check_head("wrap", 32'h7000 + 32'((k - 1) * 16), SZ_8B, 64'(32'h700 + k - 1));
      tick();
    end
    check_flags("wrap_cnt1", 0, 0, 0, 0);
    check_head("wrap_last", 32'h7000 + 32'(20 * 16), SZ_8B, 64'(32'h700 + 20));
    #2;
    rst_n = 0;
    #1;
    check_flags("mid_rst", 1, 0, 0, 0);
    idle();
    tick();
    rst_n = 1;
    tick();
    check_flags("post_rst", 1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
